// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and sequencer for the byte-addressed, word-wide data memory.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic              p0_rsp_err,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic              p1_rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                gnt_q, gnt_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef DATA_MEM_ARB_RR_EN
   logic                last_grant_q, last_grant_d;
`endif

   // Winner selection: win = 0 selects port 0, win = 1 selects port 1.
   logic                any_valid;
   logic                win;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_err;

   always_comb begin
      any_valid = p0_req_valid | p1_req_valid;
`ifdef DATA_MEM_ARB_RR_EN
      if (p0_req_valid && p1_req_valid) begin
         win = ~last_grant_q;
      end else begin
         win = ~p0_req_valid;
      end
`else
      win = ~p0_req_valid;
`endif
      sel_we    = win ? p1_req_we    : p0_req_we;
      sel_addr  = win ? p1_req_addr  : p0_req_addr;
      sel_wdata = win ? p1_req_wdata : p0_req_wdata;
      sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      gnt_d        = gnt_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
`ifdef DATA_MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      p0_req_ready = 1'b0;
      p1_req_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               p0_req_ready = ~win;
               p1_req_ready = win;
               gnt_d        = win;
               err_d        = sel_err;
               rdata_d      = '0;
`ifdef DATA_MEM_ARB_RR_EN
               last_grant_d = win;
`endif
               // Rejected requests never touch the memory-facing registers,
               // so mem_addr/mem_wdata keep the last real access.
               if (sel_err) begin
                  state_d = ST_RESP;
               end else begin
                  we_d    = sel_we;
                  addr_d  = sel_addr;
                  wdata_d = sel_wdata;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            rdata_d = we_q ? '0 : mem_rdata;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         gnt_q        <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
`ifdef DATA_MEM_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         gnt_q        <= gnt_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
`ifdef DATA_MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   always_comb begin
      busy         = (state_q != ST_IDLE);
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      mem_we       = (state_q == ST_ACCESS) &&  we_q;
      mem_re       = (state_q == ST_ACCESS) && !we_q;
      p0_rsp_valid = (state_q == ST_RESP) && !gnt_q;
      p1_rsp_valid = (state_q == ST_RESP) &&  gnt_q;
      p0_rsp_err   = p0_rsp_valid && err_q;
      p1_rsp_err   = p1_rsp_valid && err_q;
      rsp_rdata    = (state_q == ST_RESP) ? rdata_q : '0;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   localparam int MEM_BYTES = 1024;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int WORDS     = MEM_BYTES / 4;
`ifdef DATA_MEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              p0_req_valid = 1'b0, p0_req_we = 1'b0;
   logic [ADDR_W-1:0] p0_req_addr = '0;
   logic [DATA_W-1:0] p0_req_wdata = '0;
   logic              p1_req_valid = 1'b0, p1_req_we = 1'b0;
   logic [ADDR_W-1:0] p1_req_addr = '0;
   logic [DATA_W-1:0] p1_req_wdata = '0;
   logic              p0_req_ready, p1_req_ready;
   logic              p0_rsp_valid, p0_rsp_err, p1_rsp_valid, p1_rsp_err;
   logic [DATA_W-1:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we, mem_re, busy;

   int checks = 0;
   int errors = 0;

   data_mem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
      .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h0000_0005 : (32'hC0DE_0000 | 32'(i));
   endfunction

   // Simple memory: asynchronous read, write on posedge, reinitialised by reset.
   logic [31:0] mem [WORDS];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      end else if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: one transaction at a time, scheduled by cycle number.
   initial begin : model
      int cyc, free_c, acc_c, rsp_c, lastg, g, p_g;
      bit pend, p_we, p_err, acc, rsp, e, w;
      logic [31:0] p_rdata, ex_addr, ex_wdata, a, wd;
      logic [31:0] sh [WORDS];
      cyc = 0; free_c = 0; acc_c = -1; rsp_c = -1; lastg = 1; p_g = 0;
      pend = 0; p_we = 0; p_err = 0; p_rdata = '0; ex_addr = '0; ex_wdata = '0;
      for (int i = 0; i < WORDS; i++) sh[i] = init_word(i);
      @(posedge clk);
      forever begin
         @(negedge clk);
         g = -1;
         if (cyc >= free_c && (p0_req_valid || p1_req_valid)) begin
            if (p0_req_valid && p1_req_valid) g = RR_EN ? (1 - lastg) : 0;
            else g = p0_req_valid ? 0 : 1;
         end
         acc = pend && (cyc == acc_c);
         rsp = pend && (cyc == rsp_c);
         chk("p0_req_ready", 32'(p0_req_ready), 32'(g == 0));
         chk("p1_req_ready", 32'(p1_req_ready), 32'(g == 1));
         chk("busy", 32'(busy), 32'(cyc < free_c));
         chk("mem_we", 32'(mem_we), 32'(acc && p_we));
         chk("mem_re", 32'(mem_re), 32'(acc && !p_we));
         chk("mem_addr", mem_addr, ex_addr);
         chk("mem_wdata", mem_wdata, ex_wdata);
         chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(rsp && p_g == 0));
         chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(rsp && p_g == 1));
         chk("p0_rsp_err", 32'(p0_rsp_err), 32'(rsp && p_g == 0 && p_err));
         chk("p1_rsp_err", 32'(p1_rsp_err), 32'(rsp && p_g == 1 && p_err));
         if (rsp) chk("rsp_rdata", rsp_rdata, p_rdata);
         if (reset) begin
            pend = 0; free_c = cyc + 1; lastg = 1; ex_addr = '0; ex_wdata = '0;
            for (int i = 0; i < WORDS; i++) sh[i] = init_word(i);
         end else if (g >= 0) begin
            a  = (g == 0) ? p0_req_addr  : p1_req_addr;
            wd = (g == 0) ? p0_req_wdata : p1_req_wdata;
            w  = (g == 0) ? p0_req_we    : p1_req_we;
            e  = (a % 4 != 0) || (64'(a) > 64'(MEM_BYTES - 4));
            pend = 1; p_g = g; p_err = e; p_we = w; lastg = g;
            if (e) begin
               acc_c = -1; rsp_c = cyc + 1; p_rdata = '0;
            end else begin
               acc_c = cyc + 1; rsp_c = cyc + 2;
               p_rdata = w ? 32'h0 : sh[a / 4];
               if (w) sh[a / 4] = wd;
               ex_addr = a; ex_wdata = wd;
            end
            free_c = rsp_c + 1;
         end
         cyc++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input int port, input bit v, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
      end else begin
         p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Issue one request and wait for its response; lat counts cycles from accept.
   task automatic do_req(input int port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit err,
                         output logic [31:0] rdata, output int lat);
      bit got;
      err = 0; rdata = 'x; lat = -1; got = 0;
      @(posedge clk); #1 drive(port, 1, we, addr, wdata);
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         got = (port == 0) ? p0_req_ready : p1_req_ready;
      end
      @(posedge clk); #1 drive(port, 0, 0, '0, '0);
      if (!got) begin
         chk("req_ready_timeout", 32'(got), 32'd1);
         return;
      end
      got = 0;
      for (int n = 1; n <= 10 && !got; n++) begin
         @(negedge clk);
         got = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
         if (got) begin
            lat = n;
            err = (port == 0) ? p0_rsp_err : p1_rsp_err;
            rdata = rsp_rdata;
         end
      end
      if (!got) chk("rsp_valid_timeout", 32'(got), 32'd1);
   endtask

   task automatic rand_port(input int port, input int count);
      logic [31:0] addr;
      bit got;
      int r;
      for (int t = 0; t < count; t++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         r = $urandom_range(0, 9);
         case (r)
            0: addr = {22'($urandom_range(0, 255)), 8'h0} | 32'($urandom_range(1, 3));
            1: addr = 32'h400 + 32'($urandom_range(0, 15)) * 4;
            2: addr = 32'hFFFF_FFFC;
            3: addr = 32'h0000_03FC;
            default: addr = 32'($urandom_range(0, 15)) * 4;
         endcase
         @(posedge clk); #1 drive(port, 1, 1'($urandom_range(0, 1)), addr, $urandom);
         got = 0;
         for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            got = (port == 0) ? p0_req_ready : p1_req_ready;
            if (!got && $urandom_range(0, 15) == 0) break;
         end
         @(posedge clk); #1 drive(port, 0, 0, '0, '0);
      end
   endtask

   initial begin : stim
      bit err;
      logic [31:0] rd;
      int lat, ng, p1cnt, nb, busy_gaps;
      int grants [4];
      int exp_g [4];
      int pulse_c [3];

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Store then load on port 0
      do_req(0, 1, 32'h10, 32'hDEADBEEF, err, rd, lat);
      chk("st10_err", 32'(err), 0);
      chk("st10_lat", 32'(lat), 2);
      do_req(0, 0, 32'h10, 32'h0, err, rd, lat);
      chk("ld10_rdata", rd, 32'hDEADBEEF);
      chk("ld10_lat", 32'(lat), 2);

      // Port 1 load of the reset-initialised word 0
      do_reset();
      do_req(1, 0, 32'h0, 32'h0, err, rd, lat);
      chk("p1_ld0_rdata", rd, 32'h0000_0005);
      chk("p1_ld0_lat", 32'(lat), 2);

      // Alignment and bounds errors, plus the highest legal word
      do_req(0, 0, 32'h6, 32'h0, err, rd, lat);
      chk("mis6_err", 32'(err), 1);
      chk("mis6_lat", 32'(lat), 1);
      chk("mis6_rdata", rd, 0);
      do_req(1, 1, 32'h3FE, 32'h1234_5678, err, rd, lat);
      chk("oob3FE_err", 32'(err), 1);
      chk("oob3FE_lat", 32'(lat), 1);
      do_req(0, 0, 32'hFFFF_FFFC, 32'h0, err, rd, lat);
      chk("oobFFFC_err", 32'(err), 1);
      do_req(1, 0, 32'h400, 32'h0, err, rd, lat);
      chk("oob400_err", 32'(err), 1);
      do_req(1, 0, 32'h3FC, 32'h0, err, rd, lat);
      chk("ld3FC_err", 32'(err), 0);
      chk("ld3FC_rdata", rd, 32'hC0DE_00FF);

      // Both ports hold loads continuously
      do_reset();
      exp_g = RR_EN ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
      ng = 0; p1cnt = 0;
      @(posedge clk); #1;
      drive(0, 1, 0, 32'h20, '0);
      drive(1, 1, 0, 32'h24, '0);
      for (int n = 0; n < 40 && ng < 4; n++) begin
         @(negedge clk);
         if (p1_req_ready) p1cnt++;
         if (p0_req_ready) begin grants[ng] = 0; ng++; end
         else if (p1_req_ready) begin grants[ng] = 1; ng++; end
      end
      @(posedge clk); #1;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      chk("grant_count", 32'(ng), 4);
      for (int i = 0; i < ng; i++) chk($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
      chk("p1_ready_count", 32'(p1cnt), RR_EN ? 32'd2 : 32'd0);

      // Reset while a port 0 load is in ACCESS
      @(posedge clk); #1 drive(0, 1, 0, 32'h40, '0);
      nb = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (p0_req_ready) begin nb = 1; break; end
      end
      chk("rst_acc_accept", 32'(nb), 1);
      @(posedge clk); #1;
      drive(0, 0, 0, '0, '0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_acc_mem_re", 32'(mem_re), 1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_acc_busy", 32'(busy), 0);
      chk("rst_acc_rsp", 32'({p0_rsp_valid, p1_rsp_valid}), 0);
      @(negedge clk);
      chk("rst_acc_rsp_late", 32'({p0_rsp_valid, p1_rsp_valid}), 0);
      do_req(1, 0, 32'h0, 32'h0, err, rd, lat);
      chk("post_rst_rdata", rd, 32'h0000_0005);
      chk("post_rst_lat", 32'(lat), 2);

      // Back-to-back port 0 loads held valid
      @(posedge clk); #1 drive(0, 1, 0, 32'h30, '0);
      nb = 0; busy_gaps = 0;
      for (int n = 0; n < 30 && nb < 3; n++) begin
         @(negedge clk);
         if (p0_req_ready) begin pulse_c[nb] = n; nb++; end
         else if (nb > 0 && !busy) busy_gaps++;
      end
      @(posedge clk); #1 drive(0, 0, 0, '0, '0);
      chk("b2b_pulses", 32'(nb), 3);
      if (nb == 3) begin
         chk("b2b_gap1", 32'(pulse_c[1] - pulse_c[0]), 3);
         chk("b2b_gap2", 32'(pulse_c[2] - pulse_c[1]), 3);
      end
      chk("b2b_busy_gaps", 32'(busy_gaps), 0);

      // Randomized traffic on both ports
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      repeat (5) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
